bus_mem_responder: RTL
======================

Name: bus_mem_responder

Overview:
- Responder end of the core's fetch/mem request-response bus: accepts request pulses on both the fetch and mem ports and serves them from one internal single-port word memory.
- A fixed access latency models BRAM/controller delay.
- Sits between the core (or MMU output side) and on-chip memory.
- Used as the standalone memory model in core-level simulation and as the boot RAM in small builds.

Parameters:
- ADDR_W, 12, word-address width; memory holds 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from grant to response, min 1.
- BASE, 32'h0000_0000, byte base address of the memory window.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- fetch_request_enable  in  1  one-cycle fetch request pulse
- freq_mode  in  1  0=read, 1=write
- freq_addr  in  32  byte address
- freq_wdata  in  32  write data
- freq_wstrb  in  4  byte enables for write
- fetch_response_enable  out  1  one-cycle response pulse
- fresp_data  out  32  read data
- mem_request_enable  in  1  one-cycle mem request pulse
- mreq_mode  in  1  0=read, 1=write
- mreq_addr  in  32  byte address
- mreq_wdata  in  32  write data
- mreq_wstrb  in  4  byte enables
- mem_response_enable  out  1  one-cycle response pulse
- mresp_data  out  32  read data
- busy  out  1  engine not IDLE or any request pending

Behaviour:
- Clock and reset: clk is the only clock; rstn is asynchronous active-low.
- Reset values: all outputs 0; pending flags cleared; FSM in IDLE. Memory contents are not reset.
- Capture: each port has a 1-deep request buffer (mode, addr, wdata, wstrb, pending).
  - A request pulse sets pending and latches the fields.
  - A pulse on a port whose pending or in-service flag is already set is ignored; one outstanding request per port.
- Arbitration: in IDLE, if both ports are pending, mem wins. Otherwise the single pending port is granted.
  - Grant may use the pending flag or the same-cycle request pulse, so an idle request is granted in the cycle it is sampled.
- FSM:
  - IDLE: on grant, load counter=LATENCY-1 and go to ACCESS.
  - ACCESS: decrement the counter. At 0, perform the array access and go to RESP.
  - RESP: assert the granted port's response_enable for exactly 1 cycle with data. Clear that port's pending flag and return to IDLE.
  - A pending request is granted in the IDLE cycle that follows.
- Latency, uncontended: request sampled at cycle T gives the response pulse at T+LATENCY+1.
- Back-to-back:
  - Simultaneous fetch+mem at T: mem response at T+LATENCY+1, fetch response at T+2*(LATENCY+1)+1.
- Address decode: word index = (addr-BASE)[ADDR_W+1:2]; addr[1:0] is ignored.
  - Out-of-window addresses (addr<BASE or addr-BASE >= 4*2**ADDR_W): reads return 32'h0, writes are dropped. The response is still given.
- Write: the bytes selected by wstrb are updated and the others are unchanged. The response pulse carries data=0. wstrb=0 gives no update but still responds.
- Read: returns the full word and ignores wstrb.
- Response data: fresp_data/mresp_data hold their last value between pulses and change only on that port's response cycle.
- Reset mid-operation: the in-flight access is abandoned, no response is issued, and a write not yet at its access cycle is not performed.

Optional Feature:
- Macro: BUS_MEM_ERR_EN.
- When defined:
  - Adds outputs fresp_err and mresp_err (1 bit each, reset 0).
  - The error bit is asserted together with response_enable for out-of-window addresses, and for addresses with addr[1:0]!=0 when wstrb is 4'b1111 or the access is a read.
  - Writes flagged as errors are dropped.
- When undefined: no error ports, misaligned addresses are silently word-aligned, and out-of-window behaviour is as above.

Test Plan:
- Reset with LATENCY=2: mem write addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF at T -> mem_response_enable at T+3, mresp_data=0.
- Then fetch read addr=0x10 -> fetch_response_enable 3 cycles later, fresp_data=0xDEADBEEF.
- Partial write wstrb=4'b0010, wdata=0x0000AA00 to 0x10, then read -> 0xDEADAAEF.
- Fetch read and mem read issued the same cycle T:
  - mem response at T+3, fetch response at T+7.
  - Exactly one pulse each.
  - busy is high from T through T+7.
- Second fetch pulse while the first is outstanding -> ignored; only one fetch response.
- Read 0xFFFF_0000 (out of window) -> response with data 0; with BUS_MEM_ERR_EN, fresp_err=1 in the same cycle.
- Assert rstn low during ACCESS of a write to 0x20, then read 0x20 -> no response during reset, and the original word is unchanged.

Source files
------------

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: fetch/mem request-response responder over one single-port word memory.
// Define BUS_MEM_ERR_EN to add fresp_err/mresp_err for out-of-window and misaligned accesses.
module bus_mem_responder #(
    parameter int          ADDR_W  = 12,
    parameter int          LATENCY = 2,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_request_enable,
    input  logic        freq_mode,
    input  logic [31:0] freq_addr,
    input  logic [31:0] freq_wdata,
    input  logic [3:0]  freq_wstrb,
    output logic        fetch_response_enable,
    output logic [31:0] fresp_data,
    input  logic        mem_request_enable,
    input  logic        mreq_mode,
    input  logic [31:0] mreq_addr,
    input  logic [31:0] mreq_wdata,
    input  logic [3:0]  mreq_wstrb,
    output logic        mem_response_enable,
    output logic [31:0] mresp_data,
`ifdef BUS_MEM_ERR_EN
    output logic        fresp_err,
    output logic        mresp_err,
`endif
    output logic        busy
);
    localparam int          CW   = LATENCY > 1 ? $clog2(LATENCY) : 1;
    localparam logic [32:0] SPAN = 33'(1) << (ADDR_W + 2);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          sel_q;
    logic          f_pend_q, f_mode_q, m_pend_q, m_mode_q;
    logic [31:0]   f_addr_q, f_wdata_q, m_addr_q, m_wdata_q;
    logic [3:0]    f_wstrb_q, m_wstrb_q;
    logic          f_rsp_q, m_rsp_q;
    logic [31:0]   f_data_q, m_data_q;
`ifdef BUS_MEM_ERR_EN
    logic          f_err_q, m_err_q;
`endif
    logic [31:0]   mem [2**ADDR_W];

    logic              f_vld, m_vld, a_mode, in_win, bad, do_acc, we;
    logic [31:0]       a_addr, a_wdata, rdata;
    logic [3:0]        a_wstrb;
    logic [32:0]       off;
    logic [ADDR_W-1:0] idx;

    assign f_vld   = f_pend_q | fetch_request_enable;
    assign m_vld   = m_pend_q | mem_request_enable;
    assign a_mode  = sel_q ? m_mode_q  : f_mode_q;
    assign a_addr  = sel_q ? m_addr_q  : f_addr_q;
    assign a_wdata = sel_q ? m_wdata_q : f_wdata_q;
    assign a_wstrb = sel_q ? m_wstrb_q : f_wstrb_q;
    // a borrow out of the subtraction lands in off[32], so one compare covers both window edges
    assign off     = {1'b0, a_addr} - {1'b0, BASE};
    assign in_win  = off < SPAN;
    assign idx     = off[ADDR_W+1:2];
`ifdef BUS_MEM_ERR_EN
    assign bad     = ~in_win | ((|a_addr[1:0]) & (~a_mode | (&a_wstrb)));
`else
    assign bad     = ~in_win;
`endif
    assign do_acc  = state_q == ACCESS && cnt_q == '0;
    assign we      = do_acc & a_mode & ~bad;
    assign rdata   = (a_mode | ~in_win) ? '0 : mem[idx];
    assign busy    = state_q != IDLE || f_pend_q || m_pend_q || fetch_request_enable || mem_request_enable;

    assign fetch_response_enable = f_rsp_q;
    assign mem_response_enable   = m_rsp_q;
    assign fresp_data            = f_data_q;
    assign mresp_data            = m_data_q;
`ifdef BUS_MEM_ERR_EN
    assign fresp_err             = f_err_q;
    assign mresp_err             = m_err_q;
`endif

    always_ff @(posedge clk)
        if (we)
            for (int b = 0; b < 4; b++)
                if (a_wstrb[b]) mem[idx][8*b +: 8] <= a_wdata[8*b +: 8];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            f_pend_q  <= 1'b0;
            f_mode_q  <= 1'b0;
            f_addr_q  <= '0;
            f_wdata_q <= '0;
            f_wstrb_q <= '0;
            m_pend_q  <= 1'b0;
            m_mode_q  <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
            f_rsp_q   <= 1'b0;
            m_rsp_q   <= 1'b0;
            f_data_q  <= '0;
            m_data_q  <= '0;
`ifdef BUS_MEM_ERR_EN
            f_err_q   <= 1'b0;
            m_err_q   <= 1'b0;
`endif
        end else begin
            // pending stays set through service, so it also blocks pulses while in flight
            if (fetch_request_enable && !f_pend_q) begin
                f_pend_q  <= 1'b1;
                f_mode_q  <= freq_mode;
                f_addr_q  <= freq_addr;
                f_wdata_q <= freq_wdata;
                f_wstrb_q <= freq_wstrb;
            end
            if (mem_request_enable && !m_pend_q) begin
                m_pend_q  <= 1'b1;
                m_mode_q  <= mreq_mode;
                m_addr_q  <= mreq_addr;
                m_wdata_q <= mreq_wdata;
                m_wstrb_q <= mreq_wstrb;
            end
            f_rsp_q <= 1'b0;
            m_rsp_q <= 1'b0;
`ifdef BUS_MEM_ERR_EN
            f_err_q <= 1'b0;
            m_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: if (f_vld || m_vld) begin
                    sel_q   <= m_vld;
                    cnt_q   <= CW'(LATENCY - 1);
                    state_q <= ACCESS;
                end
                ACCESS: if (cnt_q == '0) begin
                    state_q <= RESP;
                    if (sel_q) begin
                        m_rsp_q  <= 1'b1;
                        m_data_q <= rdata;
`ifdef BUS_MEM_ERR_EN
                        m_err_q  <= bad;
`endif
                    end else begin
                        f_rsp_q  <= 1'b1;
                        f_data_q <= rdata;
`ifdef BUS_MEM_ERR_EN
                        f_err_q  <= bad;
`endif
                    end
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
                RESP: begin
                    state_q <= IDLE;
                    if (sel_q) m_pend_q <= 1'b0;
                    else       f_pend_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
